// File: rtl/keymgr_pkg.sv
// Shared keymgr types: sideload key request, sideload transmit FSM states and the
// all-0/all-1 share screen applied by both ends of the sideload interface.
package keymgr_pkg;

    localparam int KeyWidth = 256;

    typedef struct packed {
        logic                valid;
        logic [KeyWidth-1:0] key_share0;
        logic [KeyWidth-1:0] key_share1;
    } hw_key_req_t;

    // Codes are pairwise at least 3 bits apart so a single upset cannot land on another state.
    typedef enum logic [4:0] {
        StIdle  = 5'b01011,
        StValid = 5'b10110,
        StWipe  = 5'b11101
    } sideload_tx_state_e;

    function automatic logic valid_chk(input logic [KeyWidth-1:0] v);
        return (|v) & ~(&v);
    endfunction

endpackage

// File: rtl/keymgr_sideload_tx.sv
// Sideload key transmitter: presents screened key shares to a consumer and wipes them with entropy.
// Optional key lifetime limit enabled by defining KEYMGR_SIDELOAD_TX_LIFETIME_EN.
module keymgr_sideload_tx
    import keymgr_pkg::*;
#(
    parameter int KeyW       = KeyWidth,
    parameter int WipeCycles = 4,
    parameter int Lifetime   = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [KeyW-1:0] share0_i,
    input  logic [KeyW-1:0] share1_i,
    input  logic            clear_i,
    input  logic [KeyW-1:0] entropy_i,
    output hw_key_req_t     key_o,
    output logic            busy_o,
    output logic            err_o,
    output logic            done_o
);

    localparam int WipeCntW = $clog2(WipeCycles + 1);

    if (KeyW != KeyWidth || WipeCycles < 1 || Lifetime < 1) begin : gen_param_check
        $error("keymgr_sideload_tx: unsupported parameter combination");
    end

    sideload_tx_state_e  state_r, state_d;
    logic [KeyW-1:0]     share0_r, share0_d;
    logic [KeyW-1:0]     share1_r, share1_d;
    logic [WipeCntW-1:0] wipe_cnt_r, wipe_cnt_d;
    logic                valid_r, valid_d;
    logic                busy_r, busy_d;
    logic                err_r, err_d;
    logic                done_r, done_d;
    logic                load_ok;
    logic                expire;

    assign load_ok = valid_chk(share0_i) & valid_chk(share1_i);

`ifdef KEYMGR_SIDELOAD_TX_LIFETIME_EN
    localparam int LifeW = $clog2(Lifetime + 1);

    logic [LifeW-1:0] life_r;
    logic             load_accept;

    assign load_accept = load_i & load_ok & ~clear_i & ~expire &
                         ((state_r == StIdle) | (state_r == StValid));
    assign expire      = (state_r == StValid) && (life_r == LifeW'(Lifetime - 1));

    // Lifetime counter: restarts on every accepted load, saturates at the expiry point
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            life_r <= '0;
        end else if (load_accept) begin
            life_r <= '0;
        end else if ((state_r == StValid) && (life_r != LifeW'(Lifetime - 1))) begin
            life_r <= life_r + LifeW'(1);
        end else begin
            life_r <= life_r;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Next-state, next-share and next-output logic
    always_comb begin
        state_d    = state_r;
        share0_d   = share0_r;
        share1_d   = share1_r;
        wipe_cnt_d = wipe_cnt_r;
        err_d      = 1'b0;
        done_d     = 1'b0;
        case (state_r)
            StIdle, StValid: begin
                if (clear_i || expire) begin
                    state_d    = StWipe;
                    share0_d   = entropy_i;
                    share1_d   = ~entropy_i;
                    wipe_cnt_d = '0;
                end else if (load_i) begin
                    if (load_ok) begin
                        state_d  = StValid;
                        share0_d = share0_i;
                        share1_d = share1_i;
                    end else begin
                        // A rejected load drops the previous key as well
                        err_d      = 1'b1;
                        state_d    = StWipe;
                        share0_d   = entropy_i;
                        share1_d   = ~entropy_i;
                        wipe_cnt_d = '0;
                    end
                end else begin
                    state_d = state_r;
                end
            end
            StWipe: begin
                share0_d = entropy_i;
                share1_d = ~entropy_i;
                if (wipe_cnt_r == WipeCntW'(WipeCycles - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    wipe_cnt_d = wipe_cnt_r + WipeCntW'(1);
                end
            end
            default: begin
                state_d    = StWipe;
                share0_d   = entropy_i;
                share1_d   = ~entropy_i;
                wipe_cnt_d = '0;
            end
        endcase
        valid_d = (state_d == StValid) & valid_chk(share0_d) & valid_chk(share1_d);
        busy_d  = (state_d == StWipe);
    end

    // State, share and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= StIdle;
            share0_r   <= '0;
            share1_r   <= '0;
            wipe_cnt_r <= '0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_d;
            share0_r   <= share0_d;
            share1_r   <= share1_d;
            wipe_cnt_r <= wipe_cnt_d;
            valid_r    <= valid_d;
            busy_r     <= busy_d;
            err_r      <= err_d;
            done_r     <= done_d;
        end
    end

    assign key_o.valid      = valid_r;
    assign key_o.key_share0 = share0_r;
    assign key_o.key_share1 = share1_r;
    assign busy_o           = busy_r;
    assign err_o            = err_r;
    assign done_o           = done_r;

endmodule

// File: tb/tb_keymgr_sideload_tx.sv
// Scoreboard bench for keymgr_sideload_tx: a behavioural model queues the expected outputs of
// every clock, an independent monitor compares them on the falling edge.
module tb_keymgr_sideload_tx;
    import keymgr_pkg::*;

    localparam int KW    = KeyWidth;
    localparam int WIPES = 4;
`ifdef KEYMGR_SIDELOAD_TX_LIFETIME_EN
    localparam int  LIFE    = 16;
    localparam bit  LIFE_EN = 1'b1;
`else
    localparam int  LIFE    = 1024;
    localparam bit  LIFE_EN = 1'b0;
`endif

    typedef struct packed {
        logic          valid;
        logic [KW-1:0] s0;
        logic [KW-1:0] s1;
        logic          busy;
        logic          err;
        logic          done;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          load_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [KW-1:0] share0_i = '0;
    logic [KW-1:0] share1_i = '0;
    logic [KW-1:0] entropy_i = '0;
    hw_key_req_t   key_o;
    logic          busy_o, err_o, done_o;

    keymgr_sideload_tx #(.KeyW(KW), .WipeCycles(WIPES), .Lifetime(LIFE)) dut (
        .clk_i(clk), .rst_i(rst_i), .load_i(load_i), .share0_i(share0_i), .share1_i(share1_i),
        .clear_i(clear_i), .entropy_i(entropy_i), .key_o(key_o), .busy_o(busy_o),
        .err_o(err_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural model: mode 0 = no key, 1 = key presented, 2 = wiping
    int            m_mode = 0;
    int            m_left = 0;
    int            m_life = 0;
    logic [KW-1:0] m_s0 = '0;
    logic [KW-1:0] m_s1 = '0;
    logic          m_err = 1'b0;
    logic          m_done = 1'b0;

    function automatic bit key_ok(input logic [KW-1:0] v);
        return (v != {KW{1'b0}}) && (v != {KW{1'b1}});
    endfunction

    function automatic logic [KW-1:0] rand_key();
        logic [KW-1:0] k;
        int            sel;
        sel = $urandom_range(0, 15);
        if (sel == 0)      k = '0;
        else if (sel == 1) k = '1;
        else for (int w = 0; w < KW / 32; w++) k[w*32 +: 32] = $urandom;
        return k;
    endfunction

    task automatic start_wipe();
        m_mode = 2;
        m_left = WIPES;
        m_s0   = entropy_i;
        m_s1   = ~entropy_i;
    endtask

    task automatic model_step(input bit in_reset);
        bit expired;
        m_err  = 1'b0;
        m_done = 1'b0;
        if (in_reset) begin
            m_mode = 0; m_left = 0; m_life = 0; m_s0 = '0; m_s1 = '0;
        end else if (m_mode == 2) begin
            m_s0   = entropy_i;
            m_s1   = ~entropy_i;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_mode = 0;
                m_done = 1'b1;
            end
        end else begin
            expired = LIFE_EN && (m_mode == 1) && (m_life == LIFE - 1);
            if (clear_i || expired) begin
                start_wipe();
            end else if (load_i && key_ok(share0_i) && key_ok(share1_i)) begin
                m_mode = 1; m_life = 0; m_s0 = share0_i; m_s1 = share1_i;
            end else if (load_i) begin
                m_err = 1'b1;
                start_wipe();
            end else if (m_mode == 1) begin
                m_life = m_life + 1;
            end
        end
        exp_q.push_back('{m_mode == 1, m_s0, m_s1, m_mode == 2, m_err, m_done});
    endtask

    // One clock: drive inputs, let the edge pass, predict the outputs it produced
    task automatic tick(input bit ld, input logic [KW-1:0] s0, input logic [KW-1:0] s1,
                        input bit clr, input logic [KW-1:0] ent, input bit hold_rst, input bit mid_rst);
        rst_i = hold_rst; load_i = ld; share0_i = s0; share1_i = s1; clear_i = clr; entropy_i = ent;
        @(posedge clk);
        #1;
        if (mid_rst) rst_i = 1'b1;
        model_step(hold_rst || mid_rst);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, rand_key(), rand_key(), 1'b0, rand_key(), 1'b0, 1'b0);
    endtask

    // Monitor: every presented output set is compared with the oldest prediction
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{key_o.valid, key_o.key_share0, key_o.key_share1, busy_o, err_o, done_o};
            n_checks++;
            if (mon_a === mon_e) n_pass++;
            else $display("FAIL outputs t=%0t got v%b b%b e%b d%b s0=%h s1=%h want v%b b%b e%b d%b s0=%h s1=%h",
                          $time, mon_a.valid, mon_a.busy, mon_a.err, mon_a.done, mon_a.s0, mon_a.s1,
                          mon_e.valid, mon_e.busy, mon_e.err, mon_e.done, mon_e.s0, mon_e.s1);
        end
    end

    logic [KW-1:0] k5a, ka5, k1234, kzero, kones;
    bit            pend_rst;
    int            r;

    initial begin
        k5a   = {(KW/8){8'h5A}};
        ka5   = {(KW/8){8'hA5}};
        k1234 = {(KW/16){16'h1234}};
        kzero = '0;
        kones = '1;

        for (int i = 0; i < 3; i++) tick(1'b0, kzero, kzero, 1'b0, kzero, 1'b1, 1'b0);

        tick(1'b1, k5a, ka5, 1'b0, rand_key(), 1'b0, 1'b0);
        idle(3);
        tick(1'b0, rand_key(), rand_key(), 1'b1, k1234, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, rand_key(), rand_key(), 1'b0, k1234, 1'b0, 1'b0);

        tick(1'b1, kzero, ka5, 1'b0, rand_key(), 1'b0, 1'b0);
        idle(6);
        tick(1'b1, kones, ka5, 1'b0, rand_key(), 1'b0, 1'b0);
        idle(6);

        tick(1'b1, k5a, ka5, 1'b0, rand_key(), 1'b0, 1'b0);
        idle(2);
        tick(1'b1, ka5, k5a, 1'b0, rand_key(), 1'b0, 1'b0);
        tick(1'b1, k1234, k5a, 1'b1, rand_key(), 1'b0, 1'b0);
        idle(6);

        tick(1'b1, k5a, ka5, 1'b0, rand_key(), 1'b0, 1'b0);
        tick(1'b0, rand_key(), rand_key(), 1'b1, rand_key(), 1'b0, 1'b0);
        tick(1'b0, rand_key(), rand_key(), 1'b0, rand_key(), 1'b0, 1'b1);
        tick(1'b0, rand_key(), rand_key(), 1'b0, rand_key(), 1'b1, 1'b0);
        tick(1'b0, rand_key(), rand_key(), 1'b0, rand_key(), 1'b1, 1'b0);
        idle(8);

        tick(1'b1, k1234, ka5, 1'b0, rand_key(), 1'b0, 1'b0);
        idle(100);
        tick(1'b0, rand_key(), rand_key(), 1'b1, rand_key(), 1'b0, 1'b0);
        idle(6);

        pend_rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (pend_rst) begin
                tick(1'b0, rand_key(), rand_key(), 1'b0, rand_key(), 1'b1, 1'b0);
                pend_rst = 1'b0;
            end else begin
                pend_rst = ($urandom_range(0, 79) == 0);
                tick(r < 25, rand_key(), rand_key(), r >= 92, rand_key(), 1'b0, pend_rst);
            end
        end
        idle(8);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
